// File: rtl/lut_cfg_loader_if.sv
// Nibble-serial configuration handshake between a config source and lut_cfg_loader.
// The source drives valid/data and the loader answers with ready.
interface lut_cfg_loader_if;
  logic       cfg_valid;
  logic [3:0] cfg_data;
  logic       cfg_ready;

  modport master (output cfg_valid, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/lut_cfg_loader.sv
// Assembles 16-bit LUT truth tables from a checksummed nibble stream.
// Each word is committed into its slot of lut_init only after its XOR checksum matches.
module lut_cfg_loader #(
  parameter int NUM_LUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  lut_cfg_loader_if.slave          cfg,
  output logic [16*NUM_LUTS-1:0]   lut_init,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, DONE, ERR} state_t;

  state_t           state_reg;
  logic [15:0]      shadow_reg;
  logic [1:0]       beat_cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic [15:0]      slot_reg [NUM_LUTS];

  logic             xfer;
  logic [3:0]       checksum;

  assign xfer     = cfg.cfg_valid && ready_reg;
  assign checksum = shadow_reg[3:0] ^ shadow_reg[7:4] ^ shadow_reg[11:8] ^ shadow_reg[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shadow_reg   <= '0;
      beat_cnt_reg <= '0;
      idx_reg      <= '0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, ERR: begin
          if (start) begin
            state_reg    <= LOAD;
            idx_reg      <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            shadow_reg[{beat_cnt_reg, 2'b00} +: 4] <= cfg.cfg_data;
            beat_cnt_reg <= beat_cnt_reg + 2'd1;
            if (beat_cnt_reg == 2'd3) state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (xfer) begin
            ready_reg <= 1'b0;
            if (cfg.cfg_data == checksum) begin
              state_reg <= COMMIT;
            end else begin
              state_reg <= ERR;
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end
        end
        COMMIT: begin
          // Slot write happens in the per-slot registers below on this same edge.
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            idx_reg      <= idx_reg + 1'b1;
            beat_cnt_reg <= '0;
            state_reg    <= LOAD;
            ready_reg    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= '0;
        end else if (state_reg == COMMIT && idx_reg == IDX_W'(gi)) begin
          slot_reg[gi] <= shadow_reg;
        end
      end
      assign lut_init[16*gi +: 16] = slot_reg[gi];
    end
  endgenerate

  assign cfg.cfg_ready = ready_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with NUM_LUTS=2 and the CAFE/8001 stream.
// Cycle 1 is the cycle after the edge that samples start.
module tb_lut_cfg_loader;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [16*N-1:0] lut_init;
  logic            busy, done, err;

  lut_cfg_loader_if cfg_if ();

  lut_cfg_loader #(.NUM_LUTS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg      (cfg_if.slave),
    .lut_init (lut_init),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [3:0]  stream [10];
  int          src_idx, nxfer, ndone, cyc, done_cyc, err_cyc;
  logic [31:0] gap_pat = 32'b1011_0010_1101_0110_0101_1100_1001_1011;
  logic [31:0] lut_hist   [64];
  logic        ready_hist [64];
  logic        busy_hist  [64];
  logic        err_hist   [64];
  int          nx_hist    [64];

  task automatic record();
    lut_hist[cyc]   = lut_init;
    ready_hist[cyc] = cfg_if.cfg_ready;
    busy_hist[cyc]  = busy;
    err_hist[cyc]   = err;
    nx_hist[cyc]    = nxfer;
  endtask

  task automatic drive(input bit gap, input bit spam);
    start = spam && (cyc <= 13);
    if (src_idx < 10) begin
      cfg_if.cfg_valid = gap ? gap_pat[cyc % 32] : 1'b1;
      cfg_if.cfg_data  = stream[src_idx];
    end else begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_data  = 4'h0;
    end
  endtask

  task automatic step(input bit gap, input bit spam);
    bit xfer;
    xfer = cfg_if.cfg_valid && cfg_if.cfg_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) begin
      nxfer++;
      src_idx++;
    end
    if (done) begin
      ndone++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (err && err_cyc < 0) err_cyc = cyc;
    record();
    drive(gap, spam);
  endtask

  // Runs one load session from IDLE/ERR; abort_cyc>0 pulses rst_n low mid-session.
  task automatic session(input logic [3:0] ck1, input bit gap, input bit spam,
                         input int ncyc, input int abort_cyc);
    stream[0] = 4'hE; stream[1] = 4'hF; stream[2] = 4'hA; stream[3] = 4'hC; stream[4] = 4'h7;
    stream[5] = 4'h1; stream[6] = 4'h0; stream[7] = 4'h0; stream[8] = 4'h8; stream[9] = ck1;
    src_idx = 0; nxfer = 0; ndone = 0; cyc = 0; done_cyc = -1; err_cyc = -1;
    start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = stream[0];
    #1;
    record();
    for (int i = 0; i < ncyc; i++) begin
      step(gap, spam);
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_lut_init", lut_init, 0);
        check("rst_async_ready", cfg_if.cfg_ready, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_err_done", {err, done}, 0);
        break;
      end
    end
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 4'h0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 4'h0;
    do_reset();
    check("reset_lut_init", lut_init, 0);
    check("reset_ready", cfg_if.cfg_ready, 0);
    check("reset_busy_done_err", {busy, done, err}, 0);

    // Good stream, continuous valid (also holds valid through COMMIT).
    session(4'h9, 1'b0, 1'b0, 16, 0);
    $display("session good: done_cyc=%0d xfers=%0d lut_init=0x%08h", done_cyc, nxfer, lut_init);
    check("c0_ready_with_start", ready_hist[0], 0);
    check("c1_busy_ready", {busy_hist[1], ready_hist[1]}, 2'b11);
    check("c6_commit_ready_low", ready_hist[6], 0);
    check("c7_no_commit_xfer", nx_hist[7], 5);
    check("c7_slot0_visible", lut_hist[7], 32'h0000_CAFE);
    check("c12_slot1_not_yet", lut_hist[12], 32'h0000_CAFE);
    check("c13_lut_init", lut_hist[13], 32'h8001_CAFE);
    check("good_done_cycle", done_cyc, 13);
    check("good_done_count", ndone, 1);
    check("good_err", err_hist[13], 0);
    check("c13_busy_c14_idle", {busy_hist[13], busy_hist[14]}, 2'b10);
    check("good_xfer_count", nxfer, 10);

    // Bad second checksum from reset state.
    do_reset();
    session(4'h0, 1'b0, 1'b0, 16, 0);
    $display("session bad ck: err_cyc=%0d lut_init=0x%08h", err_cyc, lut_init);
    check("bad_err_cycle", err_cyc, 12);
    check("bad_c11_err_low", err_hist[11], 0);
    check("bad_c12_ready_low", ready_hist[12], 0);
    check("bad_lut_init", lut_init, 32'h0000_CAFE);
    check("bad_no_done", ndone, 0);
    check("bad_err_sticky", err, 1);

    // Restart from ERR.
    session(4'h9, 1'b0, 1'b0, 16, 0);
    $display("session after err: done_cyc=%0d lut_init=0x%08h", done_cyc, lut_init);
    check("restart_err_cleared", err_hist[1], 0);
    check("restart_lut_init", lut_init, 32'h8001_CAFE);
    check("restart_done_cycle", done_cyc, 13);

    // Valid gaps.
    do_reset();
    session(4'h9, 1'b1, 1'b0, 60, 0);
    $display("session gaps: done_cyc=%0d xfers=%0d lut_init=0x%08h", done_cyc, nxfer, lut_init);
    check("gap_lut_init", lut_init, 32'h8001_CAFE);
    check("gap_xfer_count", nxfer, 10);
    check("gap_done_count", ndone, 1);

    // Async reset during CHECK beat of LUT 1, then full reload.
    do_reset();
    session(4'h9, 1'b0, 1'b0, 16, 11);
    do_reset();
    session(4'h9, 1'b0, 1'b0, 16, 0);
    $display("session after mid reset: done_cyc=%0d lut_init=0x%08h", done_cyc, lut_init);
    check("post_rst_lut_init", lut_init, 32'h8001_CAFE);
    check("post_rst_done_cycle", done_cyc, 13);

    // start held while busy.
    do_reset();
    session(4'h9, 1'b0, 1'b1, 20, 0);
    $display("session start spam: done_cyc=%0d ndone=%0d lut_init=0x%08h", done_cyc, ndone, lut_init);
    check("spam_c7_lut_init", lut_hist[7], 32'h0000_CAFE);
    check("spam_done_cycle", done_cyc, 13);
    check("spam_done_count", ndone, 1);
    check("spam_lut_init", lut_init, 32'h8001_CAFE);
    check("spam_idle_after", {busy_hist[14], busy_hist[20]}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
